// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one ALU between NUM_REQ requesters.
// Accepts one operation at a time, drives registered operands to the ALU,
// waits for alu_data_valid and returns the result as a one-cycle strobe
// to the owning requester.
// Optional feature: define ALU_SCHED_TIMEOUT_EN to enable the watchdog that
// forces an error response after TIMEOUT_CYCLES without alu_data_valid.
module alu_sched #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned OPCODE_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]     req_rs_data,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]     req_imme_rs,
    input  logic [NUM_REQ*OPCODE_WIDTH-1:0]  req_op_code,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [BUS_WIDTH-1:0]             rsp_data,
    output logic                             rsp_err,
    output logic                             alu_start,
    output logic [BUS_WIDTH-1:0]             alu_rs_data,
    output logic [BUS_WIDTH-1:0]             alu_imme_rs,
    output logic [OPCODE_WIDTH-1:0]          alu_op_code,
    input  logic [BUS_WIDTH-1:0]             alu_data_out,
    input  logic                             alu_data_valid,
    output logic                             busy
);

    localparam int unsigned GW = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [GW-1:0] LAST_GRANT_RST = GW'(NUM_REQ - 1);

    if ((NUM_REQ < 2) || (NUM_REQ > 4)) begin : g_bad_num_req
        $error("alu_sched: NUM_REQ must be 2..4");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("alu_sched: TIMEOUT_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_grant, owner, grant;
    logic            any_req;
    logic            accept;
    logic            res_take;
    logic            tmo_hit;
    logic            tmo_limit;
    int unsigned     rr_idx;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant   = last_grant;
        any_req = 1'b0;
        rr_idx  = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            rr_idx = 32'(last_grant) + i;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            if (!any_req && req_valid[rr_idx]) begin
                any_req = 1'b1;
                grant   = GW'(rr_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and combinational handshake outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        alu_start = 1'b0;
        accept    = 1'b0;
        res_take  = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    accept           = 1'b1;
                    req_ready[grant] = !rst;
                    state_d          = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                alu_start = (state_q == ISSUE);
                if (alu_data_valid) begin
                    res_take = 1'b1;
                    state_d  = RESP;
                end else if (tmo_limit) begin
                    tmo_hit = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    // Operand capture on accept, grant bookkeeping and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_rs_data <= '0;
            alu_imme_rs <= '0;
            alu_op_code <= '0;
            owner       <= '0;
            last_grant  <= LAST_GRANT_RST;
            rsp_valid   <= '0;
            rsp_data    <= '0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                alu_rs_data <= req_rs_data[grant*BUS_WIDTH +: BUS_WIDTH];
                alu_imme_rs <= req_imme_rs[grant*BUS_WIDTH +: BUS_WIDTH];
                alu_op_code <= req_op_code[grant*OPCODE_WIDTH +: OPCODE_WIDTH];
                owner       <= grant;
                last_grant  <= grant;
            end
            if (res_take) begin
                rsp_data         <= alu_data_out;
                rsp_valid[owner] <= 1'b1;
            end else if (tmo_hit) begin
                rsp_data         <= '0;
                rsp_valid[owner] <= 1'b1;
            end
        end
    end

`ifdef ALU_SCHED_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Watchdog: cleared when an operation is accepted, counts ISSUE and WAIT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign tmo_limit = (tmo_cnt == 8'(TIMEOUT_CYCLES));

    // Error flag rides alongside rsp_valid; a result at the limit cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= tmo_hit;
        end
    end
`else
    assign tmo_limit = 1'b0;
    assign rsp_err   = 1'b0;
`endif

endmodule
